// File: rtl/blur_pkg.sv
// Shared types and constants for the streaming binomial blur.
package blur_pkg;

  typedef enum logic [1:0] {
    K1 = 2'd0,
    K3 = 2'd1,
    K5 = 2'd2
  } kernel_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // 1-D binomial taps; 2-D weights are their outer products
  localparam int unsigned W3 [3] = '{1, 2, 1};
  localparam int unsigned W5 [5] = '{1, 4, 6, 4, 1};

  localparam int unsigned SH3 = 4;
  localparam int unsigned SH5 = 8;

  function automatic int unsigned radius(input kernel_sel_e k);
    case (k)
      K3:      return 1;
      K5:      return 2;
      default: return 0;
    endcase
  endfunction

  // Code 3 is an alias of the 1x1 kernel
  function automatic kernel_sel_e decode_sel(input logic [1:0] sel);
    case (sel)
      2'd1:    return K3;
      2'd2:    return K5;
      default: return K1;
    endcase
  endfunction

endpackage

// File: rtl/blur_line_buffer.sv
// One-line delay: dout is the word written DEPTH enables ago.
module blur_line_buffer #(
  parameter int unsigned DEPTH = 320,
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;

  // Read-before-write at the same slot gives exactly DEPTH of delay
  assign dout = mem[ptr];

  // Circular write pointer
  always_ff @(posedge clk) begin
    if (!reset_n)
      ptr <= '0;
    else if (en)
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  end

  // Storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (en)
      mem[ptr] <= din;
  end

endmodule

// File: rtl/stream_blur_filter.sv
// Streaming RGB444 Gaussian blur with selectable 1x1/3x3/5x5 binomial kernel.
module stream_blur_filter
  import blur_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned CH_BITS    = 4,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned MAX_K      = 5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [1:0]                   kernel_sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*CH_BITS-1:0]  in_data,
  input  logic                         in_sop,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*CH_BITS-1:0]  out_data,
  output logic                         out_sop,
  output logic                         sop_err
);

  localparam int unsigned PIX_W = CHANNELS * CH_BITS;
  localparam int unsigned NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned LAT   = 2 * IMG_WIDTH + 2;
  localparam int unsigned NBEAT = NPIX + LAT;
  localparam int unsigned BW    = $clog2(NBEAT + 1);
  localparam int unsigned XW    = $clog2(IMG_WIDTH + 1);
  localparam int unsigned YW    = $clog2(IMG_HEIGHT + 1);
  localparam int unsigned A3W   = CH_BITS + 4;
  localparam int unsigned A5W   = CH_BITS + 8;
  localparam int unsigned C     = MAX_K / 2;

  state_e          state;
  kernel_sel_e     kern;
  logic [BW-1:0]   bcnt;
  logic [XW-1:0]   ox;
  logic [YW-1:0]   oy;
  logic            stall, acc_in, adv, produce, border;
  logic [PIX_W-1:0] pix_in, filt;
  logic [PIX_W-1:0] taps    [MAX_K];
  logic [PIX_W-1:0] win     [MAX_K][MAX_K];
  logic [PIX_W-1:0] win_nxt [MAX_K][MAX_K];

  assign stall   = out_valid && !out_ready;
  assign acc_in  = in_valid && in_ready;
  assign adv     = (acc_in && (state == RUN || in_sop)) || (state == FLUSH && !stall);
  assign produce = adv && (bcnt >= BW'(LAT));
  assign pix_in  = (state == FLUSH) ? '0 : in_data;
  assign taps[0] = pix_in;

  // Input acceptance per state, held low during reset
  always_comb begin
    in_ready = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE:    in_ready = 1'b1;
        RUN:     in_ready = !stall;
        default: in_ready = 1'b0;
      endcase
    end
  end

  for (genvar i = 0; i < MAX_K - 1; i++) begin : g_lb
    blur_line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PIX_W)
    ) u_lb (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (adv),
      .din     (taps[i]),
      .dout    (taps[i+1])
    );
  end

  // Next window: shift left, newest column from the line taps (row MAX_K-1 = current line).
  // Filtering the next window lets the result register on the same advance.
  always_comb begin
    for (int unsigned r = 0; r < MAX_K; r++) begin
      for (int unsigned c = 0; c < MAX_K - 1; c++)
        win_nxt[r][c] = win[r][c+1];
      win_nxt[r][MAX_K-1] = taps[MAX_K-1-r];
    end
  end

  // Window register
  always_ff @(posedge clk) begin
    if (adv)
      win <= win_nxt;
  end

  // Per-channel weighted sums with round-half-up, border passthrough
  always_comb begin
    logic [A3W-1:0] acc3;
    logic [A5W-1:0] acc5;
    int unsigned    rad;
    acc3 = '0;
    acc5 = '0;
    filt = '0;
    rad  = radius(kern);
    border = (32'(ox) < rad) || (32'(ox) + rad > IMG_WIDTH - 1) ||
             (32'(oy) < rad) || (32'(oy) + rad > IMG_HEIGHT - 1);
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      acc3 = A3W'(1) << (SH3 - 1);
      acc5 = A5W'(1) << (SH5 - 1);
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          acc3 = acc3 + A3W'(W3[r] * W3[c]) *
                 A3W'(win_nxt[C-1+r][C-1+c][ch*CH_BITS +: CH_BITS]);
      for (int unsigned r = 0; r < 5; r++)
        for (int unsigned c = 0; c < 5; c++)
          acc5 = acc5 + A5W'(W5[r] * W5[c]) *
                 A5W'(win_nxt[C-2+r][C-2+c][ch*CH_BITS +: CH_BITS]);
      case (kern)
        K3:      filt[ch*CH_BITS +: CH_BITS] = CH_BITS'(acc3 >> SH3);
        K5:      filt[ch*CH_BITS +: CH_BITS] = CH_BITS'(acc5 >> SH5);
        default: filt[ch*CH_BITS +: CH_BITS] = win_nxt[C][C][ch*CH_BITS +: CH_BITS];
      endcase
    end
    if (border)
      filt = win_nxt[C][C];
  end

  // Frame FSM, beat/coordinate counters and output register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      kern      <= K1;
      bcnt      <= '0;
      ox        <= '0;
      oy        <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_data  <= '0;
      sop_err   <= 1'b0;
    end else begin
      sop_err <= (state == RUN) && acc_in && in_sop;
      case (state)
        IDLE: begin
          if (acc_in && in_sop) begin
            kern  <= decode_sel(kernel_sel);
            bcnt  <= BW'(1);
            ox    <= '0;
            oy    <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (acc_in) begin
            bcnt <= bcnt + 1'b1;
            if (bcnt == BW'(NPIX - 1))
              state <= FLUSH;
          end
        end
        FLUSH: begin
          if (adv) begin
            if (bcnt == BW'(NBEAT - 1)) begin
              bcnt  <= '0;
              state <= IDLE;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (produce) begin
        out_valid <= 1'b1;
        out_data  <= filt;
        out_sop   <= (ox == '0) && (oy == '0);
        if (ox == XW'(IMG_WIDTH - 1)) begin
          ox <= '0;
          oy <= (oy == YW'(IMG_HEIGHT - 1)) ? '0 : oy + 1'b1;
        end else begin
          ox <= ox + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_blur_filter.sv
// Self-checking bench for stream_blur_filter: two instances (8x6 and 8x8).
module tb_stream_blur_filter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  kernel_sel = 2'd0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        out_ready = 1'b1;
  logic [11:0] in_data = '0;
  logic        sel = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_sop, a_sop_err;
  logic [11:0] a_out_data;
  logic        b_in_ready, b_out_valid, b_out_sop, b_sop_err;
  logic [11:0] b_out_data;

  logic        o_ready, o_valid, o_sop, o_err;
  logic [11:0] o_data;

  assign o_ready = sel ? b_in_ready  : a_in_ready;
  assign o_valid = sel ? b_out_valid : a_out_valid;
  assign o_sop   = sel ? b_out_sop   : a_out_sop;
  assign o_err   = sel ? b_sop_err   : a_sop_err;
  assign o_data  = sel ? b_out_data  : a_out_data;

  stream_blur_filter #(.IMG_WIDTH(8), .IMG_HEIGHT(6)) dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .kernel_sel (kernel_sel),
    .in_valid   (in_valid && !sel),
    .in_ready   (a_in_ready),
    .in_data    (in_data),
    .in_sop     (in_sop),
    .out_valid  (a_out_valid),
    .out_ready  (out_ready),
    .out_data   (a_out_data),
    .out_sop    (a_out_sop),
    .sop_err    (a_sop_err)
  );

  stream_blur_filter #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .kernel_sel (kernel_sel),
    .in_valid   (in_valid && sel),
    .in_ready   (b_in_ready),
    .in_data    (in_data),
    .in_sop     (in_sop),
    .out_valid  (b_out_valid),
    .out_ready  (out_ready),
    .out_data   (b_out_data),
    .out_sop    (b_out_sop),
    .sop_err    (b_sop_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int W = 8;
  int H = 6;
  logic [11:0] img      [64];
  logic [11:0] got_data [64];
  logic        got_sop  [64];
  logic [11:0] saved    [64];
  int n_out, first_cyc, beat19_cyc, stall_viol, err_pulses, flush_zero;
  bit in_frame = 1'b0;

  function automatic int binom(input int n, input int i);
    int v;
    v = 1;
    for (int j = 1; j <= i; j++) v = v * (n - i + j) / j;
    return v;
  endfunction

  // Reference: binomial blur of order n (0, 2 or 4) straight from coordinates
  function automatic logic [11:0] model_pix(input int x, input int y, input int ksel);
    int n, r, sum;
    logic [11:0] res;
    n = (ksel == 1) ? 2 : (ksel == 2) ? 4 : 0;
    r = n / 2;
    if (n == 0 || x < r || y < r || x > W - 1 - r || y > H - 1 - r)
      return img[y*W + x];
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum = 0;
      for (int dy = 0; dy <= n; dy++)
        for (int dx = 0; dx <= n; dx++)
          sum += binom(n, dy) * binom(n, dx) *
                 ((int'(img[(y - r + dy)*W + (x - r + dx)]) >> (4*ch)) & 15);
      sum = (sum + (1 << (2*n - 1))) >> (2*n);
      res[4*ch +: 4] = sum[3:0];
    end
    return res;
  endfunction

  task automatic run_frame(input bit use_b, input int k0, input int k1, input int k_at,
                           input int sop_at, input bit rand_ready, input int junk);
    int npix;
    sel = use_b;
    W = 8;
    H = use_b ? 8 : 6;
    npix = W * H;
    n_out = 0; first_cyc = -1; beat19_cyc = -2; stall_viol = 0;
    err_pulses = 0; flush_zero = 0; in_frame = 1'b0;
    fork
      begin : drive
        int i, budget;
        i = -junk;
        budget = 0;
        while (i < npix && budget < 4000) begin
          @(negedge clk);
          in_valid = 1'b1;
          if (i < 0) in_data = 12'($urandom);
          else       in_data = img[i];
          in_sop = (i == 0) || (i == sop_at);
          kernel_sel = 2'((i >= k_at) ? k1 : k0);
          in_frame = (i >= 1);
          #1;
          if (o_ready) begin
            if (i == 18) beat19_cyc = cyc + 1;
            i++;
          end
          budget++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sop = 1'b0;
        in_frame = 1'b0;
        #1;
        while (!o_ready && flush_zero < 200) begin
          flush_zero++;
          @(negedge clk);
          #1;
        end
      end
      begin : collect
        int budget;
        budget = 0;
        while (n_out < npix && budget < 4000) begin
          @(negedge clk);
          out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          #2;
          if (o_err) err_pulses++;
          if (in_frame && o_ready && o_valid && !out_ready) stall_viol++;
          if (o_valid && first_cyc < 0) first_cyc = cyc;
          if (o_valid && out_ready) begin
            got_data[n_out] = o_data;
            got_sop[n_out]  = o_sop;
            n_out++;
          end
          budget++;
        end
        out_ready = 1'b1;
      end
    join
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_sop !== 1'b0) begin errors++; $display("FAIL reset_out_sop: got %b expected 0", a_out_sop); end
    checks++; if (a_sop_err !== 1'b0) begin errors++; $display("FAIL reset_sop_err: got %b expected 0", a_sop_err); end
    checks++; if (a_out_data !== 12'h000) begin errors++; $display("FAIL reset_out_data: got %h expected 000", a_out_data); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", a_in_ready); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid: got %b expected 0", b_out_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b expected 1", a_in_ready); end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 48; i++) img[i] = 12'(i);
    run_frame(1'b0, 0, 0, 1000, 1000, 1'b0, 0);
    checks++; if (n_out !== 48) begin errors++; $display("FAIL pass_count: got %0d expected 48", n_out); end
    for (int i = 0; i < 48; i++) begin
      checks++;
      if (got_data[i] !== model_pix(i % W, i / W, 0)) begin
        errors++; $display("FAIL pass_data[%0d]: got %h expected %h", i, got_data[i], model_pix(i % W, i / W, 0));
      end
      checks++;
      if (got_sop[i] !== (i == 0)) begin
        errors++; $display("FAIL pass_sop[%0d]: got %b expected %b", i, got_sop[i], (i == 0));
      end
    end
    checks++;
    if (first_cyc !== beat19_cyc) begin
      errors++; $display("FAIL pass_latency: first out_valid cycle %0d expected %0d", first_cyc, beat19_cyc);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 48; i++) img[i] = 12'hA5C;
    run_frame(1'b0, 1, 1, 1000, 1000, 1'b0, 0);
    checks++; if (n_out !== 48) begin errors++; $display("FAIL flush_count: got %0d expected 48", n_out); end
    for (int i = 0; i < 48; i++) begin
      checks++;
      if (got_data[i] !== 12'hA5C) begin errors++; $display("FAIL flush_data[%0d]: got %h expected a5c", i, got_data[i]); end
    end
    checks++;
    if (flush_zero !== 18) begin errors++; $display("FAIL flush_beats: in_ready low for %0d cycles expected 18", flush_zero); end
  endtask

  task automatic test_impulse();
    for (int i = 0; i < 64; i++) img[i] = 12'h000;
    img[27] = 12'h00F;
    run_frame(1'b1, 2, 2, 1000, 1000, 1'b0, 0);
    checks++; if (n_out !== 64) begin errors++; $display("FAIL imp_count: got %0d expected 64", n_out); end
    for (int i = 0; i < 64; i++) begin
      saved[i] = got_data[i];
      checks++;
      if (got_data[i] !== model_pix(i % W, i / W, 2)) begin
        errors++; $display("FAIL imp_data[%0d]: got %h expected %h", i, got_data[i], model_pix(i % W, i / W, 2));
      end
    end
    checks++; if (got_data[27] !== 12'h002) begin errors++; $display("FAIL imp_centre: got %h expected 002", got_data[27]); end
    checks++; if (got_data[26] !== 12'h001) begin errors++; $display("FAIL imp_neighbour: got %h expected 001", got_data[26]); end
    checks++; if (got_data[25] !== 12'h000) begin errors++; $display("FAIL imp_border: got %h expected 000", got_data[25]); end
  endtask

  task automatic test_backpressure();
    run_frame(1'b1, 2, 2, 1000, 1000, 1'b1, 0);
    checks++; if (n_out !== 64) begin errors++; $display("FAIL bp_count: got %0d expected 64", n_out); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (got_data[i] !== model_pix(i % W, i / W, 2)) begin
        errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got_data[i], model_pix(i % W, i / W, 2));
      end
    end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_ready: %0d cycles with in_ready during stall expected 0", stall_viol); end
    checks++; if (got_sop[0] !== 1'b1) begin errors++; $display("FAIL bp_sop: got %b expected 1", got_sop[0]); end
  endtask

  task automatic test_sop_err();
    for (int i = 0; i < 48; i++) img[i] = 12'($urandom);
    run_frame(1'b0, 1, 2, 20, 10, 1'b0, 3);
    checks++; if (err_pulses !== 1) begin errors++; $display("FAIL soperr_pulses: got %0d expected 1", err_pulses); end
    checks++; if (n_out !== 48) begin errors++; $display("FAIL soperr_count: got %0d expected 48", n_out); end
    checks++; if (got_sop[0] !== 1'b1) begin errors++; $display("FAIL soperr_sop: got %b expected 1", got_sop[0]); end
    for (int i = 0; i < 48; i++) begin
      checks++;
      if (got_data[i] !== model_pix(i % W, i / W, 1)) begin
        errors++; $display("FAIL soperr_data[%0d]: got %h expected %h", i, got_data[i], model_pix(i % W, i / W, 1));
      end
    end
  endtask

  task automatic test_reset_in_flush();
    int accepted, budget, stray;
    sel = 1'b0; W = 8; H = 6;
    out_ready = 1'b1;
    for (int i = 0; i < 48; i++) img[i] = 12'($urandom);
    kernel_sel = 2'd1;
    accepted = 0;
    budget = 0;
    while (accepted < 48 && budget < 500) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = img[accepted];
      in_sop   = (accepted == 0);
      #1;
      if (o_ready) accepted++;
      budget++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sop = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    checks++; if (accepted !== 48) begin errors++; $display("FAIL rst_accepted: got %0d expected 48", accepted); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_idle: in_ready got %b expected 1", a_in_ready); end
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      #2;
      if (a_out_valid) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rst_no_partial: got %0d outputs expected 0", stray); end
    for (int i = 0; i < 48; i++) img[i] = 12'($urandom);
    run_frame(1'b0, 2, 2, 1000, 1000, 1'b0, 0);
    checks++; if (n_out !== 48) begin errors++; $display("FAIL rst_count: got %0d expected 48", n_out); end
    for (int i = 0; i < 48; i++) begin
      checks++;
      if (got_data[i] !== model_pix(i % W, i / W, 2)) begin
        errors++; $display("FAIL rst_data[%0d]: got %h expected %h", i, got_data[i], model_pix(i % W, i / W, 2));
      end
      checks++;
      if (got_sop[i] !== (i == 0)) begin
        errors++; $display("FAIL rst_sop[%0d]: got %b expected %b", i, got_sop[i], (i == 0));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_flush();
    test_impulse();
    test_backpressure();
    test_sop_err();
    test_reset_in_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_blur_filter.md
Name: stream_blur_filter

Overview:
- Streaming 2-D Gaussian blur for the RGB444 video path, placed between the camera/pixel source and the VGA output stage.
- Accepts one pixel per valid/ready beat and buffers MAX_K-1 lines internally.
- Applies a per-frame selectable 1x1, 3x3 or 5x5 binomial kernel per colour channel, normalised by shift, and emits exactly IMG_WIDTH*IMG_HEIGHT pixels per frame with flow control.

Parameters:
- IMG_WIDTH, 320: pixels per line.
- IMG_HEIGHT, 240: lines per frame.
- CH_BITS, 4: bits per colour channel.
- CHANNELS, 3: colour channels per pixel; pixel width = CHANNELS*CH_BITS.
- MAX_K, 5: largest kernel edge; the line-buffer count is MAX_K-1.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- kernel_sel  in  2  0=1x1, 1=3x3, 2=5x5, 3=1x1.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts a pixel this cycle.
- in_data  in  CHANNELS*CH_BITS  pixel, channel 0 in the LSBs.
- in_sop  in  1  marks pixel (0,0) of a frame.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts.
- out_data  out  CHANNELS*CH_BITS  blurred pixel.
- out_sop  out  1  marks output pixel (0,0).
- sop_err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset (reset_n low at an edge): state=IDLE; in_ready, out_valid, out_sop, sop_err=0; out_data=0; counters=0. Line-buffer RAM contents are not reset.
- FSM IDLE -> RUN -> FLUSH -> IDLE.
  - IDLE: in_ready=1. Beats without in_sop are consumed and dropped. A beat with in_sop is pixel 0; kernel_sel is latched; go to RUN.
  - RUN: in_ready = !out_valid || out_ready. After the accepted beat index W*H-1, go to FLUSH.
  - FLUSH: in_ready=0. The block generates 2*IMG_WIDTH+2 internal zero-pixel beats under the same stall rule, then returns to IDLE.
- Advance: one window shift per accepted input beat or flush beat.
  - Stall = out_valid && !out_ready. Nothing shifts while stalled.
- Window: MAX_K x MAX_K pixel register fed from the line-buffer taps. The centre sits at offset (2,2) for every kernel size.
- Latency: output pixel p is computed on the advance of beat p+2*IMG_WIDTH+2 and is registered, so out_valid rises the cycle after that advance. Output order is raster order.
- Weights, separable binomial per channel:
  - 3x3 = [1 2 1] outer [1 2 1]; sum 16; shift 4.
  - 5x5 = [1 4 6 4 1] outer itself; sum 256; shift 8.
  - 1x1 = centre only.
- Arithmetic: unsigned accumulation per channel, widths CH_BITS+4 (3x3) and CH_BITS+8 (5x5). Result = (sum + 2^(s-1)) >> s, with round-half-up. The result never exceeds 2^CH_BITS-1 and is not saturated.
- Borders: with r=1 (3x3) or r=2 (5x5), the output equals the unfiltered centre pixel when x<r, x>W-1-r, y<r or y>H-1-r. Coordinates are tracked by output x/y counters.
- out_sop=1 exactly with output pixel 0.
- kernel_sel changes mid-frame have no effect until the next accepted in_sop.
- in_sop on any beat other than pixel 0 while in RUN: the pixel is processed as normal data, sop_err pulses for one cycle, and frame counters are unaffected.
- An in_sop beat arriving in FLUSH is not accepted (in_ready=0); it waits until IDLE.
- Reset in any state aborts the frame; no partial output follows.

Decomposition:
- Package blur_pkg holds:
  - kernel_sel_e enum (K1, K3, K5).
  - fsm state_e (IDLE, RUN, FLUSH).
  - 1-D weight constants W3={1,2,1} and W5={1,4,6,4,1}.
  - shift constants 4 and 8.
  - function radius(kernel_sel_e).
- Sub-module blur_line_buffer: one IMG_WIDTH-deep, CHANNELS*CH_BITS-wide delay line with an enable. It is instantiated MAX_K-1 times in cascade.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=6, kernel_sel=0, ramp pixel i = i:
  - 48 outputs equal to the ramp.
  - out_sop only on the first output.
  - First out_valid one cycle after the 19th accepted beat.
- kernel_sel=1, constant 12'hA5C frame, out_ready=1 -> all 48 outputs are 12'hA5C; exactly 18 flush beats follow, with in_ready=0 throughout.
- W=H=8, kernel_sel=2, all zero except (3,3)=12'h00F:
  - Output (3,3) = 12'h002, from (540+128)>>8.
  - Output (2,3) = 12'h001.
  - Output (1,3) = 12'h000 (border passthrough).
- Repeat the previous scenario with out_ready toggling pseudo-randomly at 50%:
  - Output data and order are identical.
  - in_ready is never 1 while out_valid && !out_ready.
- in_sop pulsed on pixel 10 and kernel_sel changed 1->2 mid-frame -> sop_err pulses once; the frame still yields 48 outputs with 3x3 results.
- reset_n low for one cycle during FLUSH -> next cycle out_valid=0, state IDLE; a following frame produces correct results and out_sop.
